log2_range_reduce: RTL
======================

Name: log2_range_reduce

Overview:
Sequential argument-reduction front end for the float32 log2 datapath. It takes an IEEE-754 single-precision operand and classifies it as a special case or an ordinary value. Subnormals are normalised iteratively, and each ordinary value is split into an integer exponent k and a float m in [sqrt(2)/2, sqrt(2)) with x = m * 2^k. It feeds the downstream polynomial log stage through a valid/ready handshake.

Parameters:
OFFS, 32'h004AFB0D, added to the reduction word (32'h3F800000 - 32'h3F3504F3).
SQRT2_2, 32'h3F3504F3, float bit pattern of sqrt(2)/2; it is the base of the reduced mantissa.

Ports:
clk  input  1  clock
rst  input  1  reset
in_valid  input  1  operand valid
in_ready  output  1  stage can accept an operand
x_i  input  32  float32 operand
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
k_o  output  9  signed exponent k, range -149..+128
m_o  output  32  float32 reduced mantissa m
special_o  output  1  1 = result is final; downstream bypasses polynomial
special_val_o  output  32  final log2 value when special_o=1, else 0

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, k_o=0, m_o=0, special_o=0, special_val_o=0, FSM=IDLE.
- in_ready is combinational: 1 in IDLE, or in OUT while out_ready=1. It is 0 in NORM.
- Accept condition: in_valid & in_ready at a rising edge, cycle T. x_i is registered.
- FSM states:
  - IDLE: no result held.
  - NORM: subnormal shift loop.
  - OUT: out_valid=1; outputs held.
- Classification at accept, in priority order:
  1. x_i[30:0]==0 (±0): special, value 32'hFF800000.
  2. x_i[31]=1: special, value 32'h7FFFFFFF.
  3. x_i>=32'h7F800000 (+inf or NaN): special, value = x_i.
  4. x_i==32'h3F800000: special, value 0.
  5. Exponent field E!=0: normal, go to OUT.
  6. Otherwise subnormal: go to NORM.
- Normal path: e = E-127. Exponent and fraction F are registered. Results appear at T+1.
- Subnormal path: load mantissa {1'b0, F}, e=-126.
  - Each NORM cycle shifts the mantissa left 1 and decrements e.
  - NORM exits when mantissa bit 23 is set, after s shifts (1..23).
  - F becomes mantissa[22:0]. out_valid rises at T+1+s.
- Reduction for all non-special values:
  - t = {9'b0, F} + OFFS.
  - c = t[23], which is 1 when F >= 23'h3504F3.
  - k_o = e + c.
  - m_o = (t & 32'h007FFFFF) + SQRT2_2.
  - Use 32-bit unsigned adds and 9-bit two's-complement k.
- Special path outputs: k_o=0, m_o=0, special_o=1. Non-special: special_o=0, special_val_o=0.
- OUT state:
  - Outputs are stable while out_valid & !out_ready.
  - On out_ready with no new accept: go to IDLE, out_valid=0.
  - On out_ready with a simultaneous accept: go to the new operand's next state. Full throughput for normals, no bubble.
- Reset mid-NORM or mid-OUT: the operand is discarded, and out_valid=0 after the reset edge.
- No combinational path from in_valid to out_valid. The only in/out combinational path is out_ready to in_ready.

Optional Feature:
Macro: LOG2_RR_FTZ_EN.
- When defined: subnormal inputs are flushed to zero. They are classified as special with value 32'hFF800000, latency 1. The NORM state and shift logic are not built.
- When undefined: full subnormal normalisation as described in Behaviour.

Test Plan:
- x_i=32'h3F800000 → next cycle: special_o=1, special_val_o=32'h00000000, k_o=0.
- x_i=32'h40000000 (2.0) → T+1: special_o=0, k_o=+1, m_o=32'h3F800000. Then x_i=32'h3FC00000 (1.5) → k_o=+1, m_o=32'h3F400000.
- x_i=32'h00000001 → out_valid at T+24, k_o=-149, m_o=32'h3F800000, in_ready=0 throughout NORM. With LOG2_RR_FTZ_EN: T+1, special_val_o=32'hFF800000.
- Specials: 32'h80000000 → 32'hFF800000; 32'hC0000000 → 32'h7FFFFFFF; 32'h7F800000 → 32'h7F800000; 32'h7FC00001 → 32'h7FC00001.
- Back-to-back normals with out_ready=1 → one result per cycle. Hold out_ready=0 for 5 cycles → k_o/m_o stable, in_ready=0; results are released in order.
- Assert rst during NORM (x_i=32'h00000004) → out_valid=0 and in_ready=1 the cycle after; a following operand 32'h40800000 gives k_o=+2, m_o=32'h3F800000.

Source files
------------

// File: rtl/log2_range_reduce.sv
// log2 argument-reduction front end: classifies a float32 operand and splits it into k and m.
// Define LOG2_RR_FTZ_EN to flush subnormal inputs to zero. The NORM state and shifter are then omitted.
module log2_range_reduce #(
  parameter logic [31:0] OFFS    = 32'h004AFB0D,
  parameter logic [31:0] SQRT2_2 = 32'h3F3504F3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [8:0]  k_o,
  output logic [31:0] m_o,
  output logic        special_o,
  output logic [31:0] special_val_o
);

`ifdef LOG2_RR_FTZ_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_OUT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_NORM = 2'd1, S_OUT = 2'd2} state_t;
`endif

  typedef struct packed {
    logic [8:0]  k;
    logic [31:0] m;
  } red_t;

  // Adding OFFS carries into bit 23 exactly when the fraction is at or above sqrt(2)/2.
  // That bumps k. The masked remainder rebased on SQRT2_2 gives m in [sqrt(2)/2, sqrt(2)).
  function automatic red_t reduce(input logic [8:0] e, input logic [22:0] f);
    logic [31:0] t;
    red_t        r;
    t   = {9'b0, f} + OFFS;
    r.k = e + {8'b0, t[23]};
    r.m = (t & 32'h007FFFFF) + SQRT2_2;
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [8:0]  k_q, k_d;
  logic [31:0] m_q, m_d;
  logic        sp_q, sp_d;
  logic [31:0] spv_q, spv_d;
  logic        accept;
  logic [8:0]  exp_x;
  red_t        red_x;

`ifndef LOG2_RR_FTZ_EN
  logic [23:0] mant_q, mant_d;
  logic [8:0]  e_q, e_d;
  logic [23:0] mant_sh;
  logic [8:0]  e_sh;
  red_t        red_n;
`endif

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_OUT) && out_ready);
  assign out_valid = (state_q == S_OUT);
  assign accept    = in_valid && in_ready;
  assign exp_x     = {1'b0, x_i[30:23]} - 9'd127;
  assign red_x     = reduce(exp_x, x_i[22:0]);

  assign k_o           = k_q;
  assign m_o           = m_q;
  assign special_o     = sp_q;
  assign special_val_o = spv_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    m_d     = m_q;
    sp_d    = sp_q;
    spv_d   = spv_q;
`ifndef LOG2_RR_FTZ_EN
    mant_d  = mant_q;
    e_d     = e_q;
    mant_sh = {mant_q[22:0], 1'b0};
    e_sh    = e_q - 9'd1;
    red_n   = reduce(e_sh, mant_sh[22:0]);
`endif

    unique case (state_q)
`ifndef LOG2_RR_FTZ_EN
      S_NORM: begin
        mant_d = mant_sh;
        e_d    = e_sh;
        if (mant_sh[23]) begin
          k_d     = red_n.k;
          m_d     = red_n.m;
          sp_d    = 1'b0;
          spv_d   = '0;
          state_d = S_OUT;
        end
      end
`endif
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    // A new accept overrides the drain to IDLE, so back-to-back operands need no bubble.
    if (accept) begin
      k_d     = '0;
      m_d     = '0;
      sp_d    = 1'b1;
      state_d = S_OUT;
      if (x_i[30:0] == 31'd0) begin
        spv_d = 32'hFF800000;
      end else if (x_i[31]) begin
        spv_d = 32'h7FFFFFFF;
      end else if (x_i >= 32'h7F800000) begin
        spv_d = x_i;
      end else if (x_i == 32'h3F800000) begin
        spv_d = '0;
      end else if (x_i[30:23] != 8'd0) begin
        k_d   = red_x.k;
        m_d   = red_x.m;
        sp_d  = 1'b0;
        spv_d = '0;
      end else begin
`ifdef LOG2_RR_FTZ_EN
        spv_d = 32'hFF800000;
`else
        sp_d    = 1'b0;
        spv_d   = '0;
        mant_d  = {1'b0, x_i[22:0]};
        e_d     = -9'sd126;
        state_d = S_NORM;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      m_q     <= '0;
      sp_q    <= 1'b0;
      spv_q   <= '0;
`ifndef LOG2_RR_FTZ_EN
      mant_q  <= '0;
      e_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      m_q     <= m_d;
      sp_q    <= sp_d;
      spv_q   <= spv_d;
`ifndef LOG2_RR_FTZ_EN
      mant_q  <= mant_d;
      e_q     <= e_d;
`endif
    end
  end

endmodule
